// File: rtl/prog_sequencer.sv
// Program sequencer: owns the PC and a return-address stack, fetches over a
// req/ack handshake and holds each instruction until the datapath retires it.
module prog_sequencer #(
    parameter int PC_W        = 8,
    parameter int INSTR_W     = 9,
    parameter int STACK_DEPTH = 4,
    parameter int HALT_ADDR   = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             imem_req,
    output logic [PC_W-1:0]                  imem_addr,
    input  logic                             imem_ack,
    input  logic [INSTR_W-1:0]               imem_data,
    output logic                             instr_valid,
    output logic [INSTR_W-1:0]               instr,
    output logic [PC_W-1:0]                  pc,
    input  logic                             exec_done,
    input  logic                             branch,
    input  logic                             call,
    input  logic                             ret,
    input  logic [PC_W-1:0]                  target,
    output logic                             done,
    output logic                             stack_err,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SLOTS = 1 << IDX_W;
    localparam logic [PC_W-1:0]  HALT_PC  = PC_W'(HALT_ADDR);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        HALT  = 3'd3,
        ERROR = 3'd4
    } state_e;

    state_e             stateR, stateNextS;
    logic [PC_W-1:0]    pcR, pcNextS, pcPlusOneS;
    logic [INSTR_W-1:0] instrR;
    logic [LVL_W-1:0]   levelR, levelNextS;
    logic [PC_W-1:0]    stackR [SLOTS];
    logic [IDX_W-1:0]   pushIdxS, popIdxS;
    logic               pushS, loadS, stackFaultS;
    logic               reqR, validR, doneR, errR;
    logic               reqNextS, validNextS, doneNextS, errNextS;

    assign pcPlusOneS = pcR + PC_W'(1);
    // Occupancy never exceeds SLOTS, so modular index arithmetic stays exact.
    assign pushIdxS   = levelR[IDX_W-1:0];
    assign popIdxS    = pushIdxS - IDX_W'(1);

    assign imem_req    = reqR;
    assign imem_addr   = pcR;
    assign instr_valid = validR;
    assign instr       = instrR;
    assign pc          = pcR;
    assign done        = doneR;
    assign stack_err   = errR;
    assign stack_level = levelR;

    // State, PC, instruction latch, stack level and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateR <= IDLE;
            pcR    <= '0;
            instrR <= '0;
            levelR <= '0;
            reqR   <= 1'b0;
            validR <= 1'b0;
            doneR  <= 1'b0;
            errR   <= 1'b0;
        end else begin
            stateR <= stateNextS;
            pcR    <= pcNextS;
            levelR <= levelNextS;
            if (loadS) begin
                instrR <= imem_data;
            end
            reqR   <= reqNextS;
            validR <= validNextS;
            doneR  <= doneNextS;
            errR   <= errNextS;
        end
    end

    // Return-address storage; only the level decides which entries are live.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                stackR[i] <= '0;
            end
        end else if (pushS) begin
            stackR[pushIdxS] <= pcPlusOneS;
        end
    end

    // Next-state, next-PC and stack control.
    always_comb begin
        stateNextS  = stateR;
        pcNextS     = pcR;
        levelNextS  = levelR;
        pushS       = 1'b0;
        loadS       = 1'b0;
        stackFaultS = 1'b0;
        case (stateR)
            IDLE, HALT, ERROR: begin
                if (start) begin
                    stateNextS = FETCH;
                    pcNextS    = '0;
                    levelNextS = '0;
                end else begin
                    stateNextS = stateR;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    loadS      = 1'b1;
                    stateNextS = ISSUE;
                end else begin
                    stateNextS = FETCH;
                end
            end
            ISSUE: begin
                if (exec_done) begin
                    // ret outranks call, so a simultaneous call never pushes.
                    if (ret) begin
                        if (levelR == LVL_W'(0)) begin
                            stackFaultS = 1'b1;
                        end else begin
                            levelNextS = levelR - LVL_W'(1);
                            pcNextS    = stackR[popIdxS];
                        end
                    end else if (call) begin
                        if (levelR == FULL_LVL) begin
                            stackFaultS = 1'b1;
                        end else begin
                            pushS      = 1'b1;
                            levelNextS = levelR + LVL_W'(1);
                            pcNextS    = target;
                        end
                    end else if (branch) begin
                        pcNextS = target;
                    end else begin
                        pcNextS = pcPlusOneS;
                    end
                    if (stackFaultS) begin
                        stateNextS = ERROR;
                    end else if (pcNextS == HALT_PC) begin
                        stateNextS = HALT;
                    end else begin
                        stateNextS = FETCH;
                    end
                end else begin
                    stateNextS = ISSUE;
                end
            end
            default: begin
                stateNextS = IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state, registered above.
    always_comb begin
        reqNextS   = 1'b0;
        validNextS = 1'b0;
        doneNextS  = 1'b0;
        errNextS   = 1'b0;
        case (stateNextS)
            FETCH:   reqNextS   = 1'b1;
            ISSUE:   validNextS = 1'b1;
            HALT:    doneNextS  = 1'b1;
            ERROR:   errNextS   = 1'b1;
            default: reqNextS   = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: scoreboard of fetched words plus
// scenario tasks for flow, wait states, call/ret, overflow, halt and reset.
module tb_prog_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [8:0] imem_data = 9'h000;
    logic       instr_valid;
    logic [8:0] instr;
    logic [7:0] pc;
    logic       exec_done = 1'b0;
    logic       branch = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [7:0] target = 8'h00;
    logic       done;
    logic       stack_err;
    logic [2:0] stack_level;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] pc;
        logic [8:0] word;
    } exp_t;
    exp_t sbQ[$];

    prog_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_valid(instr_valid), .instr(instr), .pc(pc),
        .exec_done(exec_done), .branch(branch), .call(call), .ret(ret), .target(target),
        .done(done), .stack_err(stack_err), .stack_level(stack_level)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] mem_word(input logic [7:0] a);
        return {a[0], a} ^ 9'h15A;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
        branch = 1'b0; call = 1'b0; ret = 1'b0; target = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Memory model: acks after 'waits' cycles and pushes the expected word.
    task automatic fetch(input int waits, input logic [7:0] expPc, output int reqCnt, output int validCnt);
        reqCnt = 0;
        validCnt = 0;
        for (int i = 0; i <= waits; i++) begin
            if (imem_req) reqCnt++;
            if (instr_valid) validCnt++;
            if (i == waits) begin
                imem_ack = 1'b1;
                imem_data = mem_word(imem_addr);
                sbQ.push_back('{expPc, mem_word(expPc)});
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        imem_data = 9'h000;
    endtask

    task automatic retire(input logic br, input logic cl, input logic rt, input logic [7:0] tgt);
        exec_done = 1'b1; branch = br; call = cl; ret = rt; target = tgt;
        @(negedge clk);
        exec_done = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0; target = 8'h00;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({imem_req, instr_valid, done, stack_err} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got req/valid/done/err=%b, want 0000", {imem_req, instr_valid, done, stack_err});
        end
        tests++;
        if (pc !== 8'h00 || instr !== 9'h000 || stack_level !== 3'd0) begin
            fails++;
            $display("FAIL reset_regs: got pc=%h instr=%h lvl=%0d, want 00 000 0", pc, instr, stack_level);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (imem_req !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_req: got req=%b, want 0", imem_req);
        end
    endtask

    task automatic test_sequential();
        exp_t e;
        int rc, vc;
        do_reset();
        do_start();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== 8'(k) || pc !== 8'(k)) begin
                fails++;
                $display("FAIL seq_fetch%0d: got req=%b addr=%h pc=%h, want 1 %h", k, imem_req, imem_addr, pc, 8'(k));
            end
            fetch(0, 8'(k), rc, vc);
            e = sbQ.pop_front();
            tests++;
            if (instr_valid !== 1'b1 || pc !== e.pc || instr !== e.word) begin
                fails++;
                $display("FAIL seq_issue%0d: got valid=%b pc=%h instr=%h, want 1 %h %h", k, instr_valid, pc, instr, e.pc, e.word);
            end
            retire(1'b0, 1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic test_wait_states();
        exp_t e;
        int rc, vc;
        do_reset();
        do_start();
        fetch(3, 8'h00, rc, vc);
        tests++;
        if (rc != 4 || vc != 0) begin
            fails++;
            $display("FAIL wait_req: got req cycles=%0d valid cycles=%0d, want 4 0", rc, vc);
        end
        // stray ack and start while the instruction is held
        imem_ack = 1'b1; imem_data = 9'h1FF; start = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0; imem_data = 9'h000; start = 1'b0;
        e = sbQ.pop_front();
        tests++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== e.pc || instr !== e.word) begin
            fails++;
            $display("FAIL stray_ack: got valid=%b req=%b pc=%h instr=%h, want 1 0 %h %h", instr_valid, imem_req, pc, instr, e.pc, e.word);
        end
        retire(1'b0, 1'b0, 1'b0, 8'h00);
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin
            fail_line("wait_next", imem_req, imem_addr);
        end
    endtask

    function automatic void fail_line(input string name, input logic r, input logic [7:0] a);
        fails++;
        $display("FAIL %s: got req=%b addr=%h, want 1 01", name, r, a);
    endfunction

    task automatic test_call_ret();
        int tPc[6] = '{8'h00, 8'h05, 8'h40, 8'h06, 8'h10, 8'h07};
        int tBr[6] = '{1, 0, 0, 0, 0, 0};
        int tCl[6] = '{0, 1, 1, 1, 0, 0};
        int tRt[6] = '{0, 0, 1, 0, 1, 0};
        int tTg[6] = '{8'h05, 8'h40, 8'h80, 8'h10, 8'h00, 8'h00};
        int tLv[6] = '{0, 1, 0, 1, 0, 0};
        int tNx[6] = '{8'h05, 8'h40, 8'h06, 8'h10, 8'h07, 8'h08};
        exp_t e;
        int rc, vc;
        do_reset();
        do_start();
        for (int i = 0; i < 6; i++) begin
            fetch(0, 8'(tPc[i]), rc, vc);
            e = sbQ.pop_front();
            tests++;
            if (instr_valid !== 1'b1 || pc !== e.pc || instr !== e.word) begin
                fails++;
                $display("FAIL cr_issue%0d: got valid=%b pc=%h instr=%h, want 1 %h %h", i, instr_valid, pc, instr, e.pc, e.word);
            end
            retire(tBr[i][0], tCl[i][0], tRt[i][0], 8'(tTg[i]));
            tests++;
            if (imem_req !== 1'b1 || pc !== 8'(tNx[i]) || stack_level !== 3'(tLv[i])) begin
                fails++;
                $display("FAIL cr_next%0d: got req=%b pc=%h lvl=%0d, want 1 %h %0d", i, imem_req, pc, stack_level, 8'(tNx[i]), tLv[i]);
            end
        end
        // ret with an empty stack
        fetch(0, 8'h08, rc, vc);
        e = sbQ.pop_front();
        retire(1'b0, 1'b0, 1'b1, 8'h00);
        tests++;
        if (stack_err !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 8'h08 || stack_level !== 3'd0) begin
            fails++;
            $display("FAIL underflow: got err=%b valid=%b req=%b pc=%h lvl=%0d, want 1 0 0 08 0", stack_err, instr_valid, imem_req, pc, stack_level);
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        int rc, vc;
        do_reset();
        do_start();
        for (int i = 0; i < 5; i++) begin
            fetch(0, (i == 0) ? 8'h00 : 8'(8'h1F + i), rc, vc);
            e = sbQ.pop_front();
            tests++;
            if (pc !== e.pc || instr !== e.word) begin
                fails++;
                $display("FAIL ovf_issue%0d: got pc=%h instr=%h, want %h %h", i, pc, instr, e.pc, e.word);
            end
            retire(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
            if (i < 4) begin
                tests++;
                if (stack_level !== 3'(i + 1) || stack_err !== 1'b0 || imem_req !== 1'b1) begin
                    fails++;
                    $display("FAIL ovf_push%0d: got lvl=%0d err=%b req=%b, want %0d 0 1", i, stack_level, stack_err, imem_req, i + 1);
                end
            end
        end
        repeat (2) @(negedge clk);
        tests++;
        if (stack_err !== 1'b1 || pc !== 8'h23 || instr_valid !== 1'b0 || imem_req !== 1'b0 || stack_level !== 3'd4) begin
            fails++;
            $display("FAIL overflow: got err=%b pc=%h valid=%b req=%b lvl=%0d, want 1 23 0 0 4", stack_err, pc, instr_valid, imem_req, stack_level);
        end
        do_start();
        tests++;
        if (stack_err !== 1'b0 || pc !== 8'h00 || imem_req !== 1'b1 || stack_level !== 3'd0) begin
            fails++;
            $display("FAIL ovf_restart: got err=%b pc=%h req=%b lvl=%0d, want 0 00 1 0", stack_err, pc, imem_req, stack_level);
        end
    endtask

    task automatic test_halt();
        exp_t e;
        int rc, vc, reqSeen;
        do_reset();
        do_start();
        fetch(0, 8'h00, rc, vc);
        e = sbQ.pop_front();
        retire(1'b1, 1'b0, 1'b0, 8'hFE);
        fetch(0, 8'hFE, rc, vc);
        e = sbQ.pop_front();
        tests++;
        if (pc !== e.pc || instr !== e.word) begin
            fails++;
            $display("FAIL halt_issue: got pc=%h instr=%h, want %h %h", pc, instr, e.pc, e.word);
        end
        retire(1'b0, 1'b0, 1'b0, 8'h00);
        reqSeen = 0;
        for (int i = 0; i < 3; i++) begin
            if (imem_req) reqSeen++;
            @(negedge clk);
        end
        tests++;
        if (done !== 1'b1 || pc !== 8'hFF || reqSeen != 0 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL halt: got done=%b pc=%h req cycles=%0d valid=%b, want 1 ff 0 0", done, pc, reqSeen, instr_valid);
        end
        do_start();
        tests++;
        if (done !== 1'b0 || pc !== 8'h00 || imem_req !== 1'b1) begin
            fails++;
            $display("FAIL halt_restart: got done=%b pc=%h req=%b, want 0 00 1", done, pc, imem_req);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        do_start();
        #2 reset = 1'b0;
        #1;
        tests++;
        if (imem_req !== 1'b0 || pc !== 8'h00) begin
            fails++;
            $display("FAIL async_drop: got req=%b pc=%h, want 0 00", imem_req, pc);
        end
        imem_ack = 1'b1; imem_data = 9'h0AA;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0; imem_data = 9'h000;
        repeat (2) @(negedge clk);
        tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 9'h000) begin
            fails++;
            $display("FAIL late_ack: got req=%b valid=%b instr=%h, want 0 0 000", imem_req, instr_valid, instr);
        end
        do_start();
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            fails++;
            $display("FAIL resume: got req=%b addr=%h, want 1 00", imem_req, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_call_ret();
        test_overflow();
        test_halt();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
